// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants and elaboration helpers
package bcd_pkg;

    localparam logic [3:0] BCD_ZERO = 4'h0;
    localparam logic [3:0] BCD_NINE = 4'h9;
    localparam int         BCD_MAX_NIBBLES = 16;

    function automatic logic [63:0] int_to_bcd(input int value, input int digits);
        logic [63:0] r;
        int          v;
        r = '0;
        v = value;
        for (int i = 0; i < BCD_MAX_NIBBLES; i++) begin
            if (i < digits) begin
                r[4*i +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    // Zero padding above the real digits is itself valid BCD, so callers zero-extend.
    function automatic logic is_valid_bcd(input logic [63:0] vec);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_MAX_NIBBLES; i++) begin
            if (vec[4*i +: 4] > BCD_NINE) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// rtl/bcd_digit_step.sv - single BCD digit increment/decrement with ripple in/out
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic       step_in,
    input  logic       down,
    input  logic [3:0] digit,
    output logic [3:0] next,
    output logic       carry_out,
    output logic       borrow_out
);

    always_comb begin
        next       = digit;
        carry_out  = 1'b0;
        borrow_out = 1'b0;
        if (step_in) begin
            if (!down) begin
                if (digit >= BCD_NINE) begin
                    next      = BCD_ZERO;
                    carry_out = 1'b1;
                end else begin
                    next = digit + 4'd1;
                end
            end else begin
                if (digit == BCD_ZERO) begin
                    next       = BCD_NINE;
                    borrow_out = 1'b1;
                end else begin
                    next = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// rtl/bcd_mod_counter.sv - N-digit BCD up/down modulo counter with range-checked load
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int MIN_VAL   = 1,
    parameter int MAX_VAL   = 12,
    parameter int RESET_VAL = 0,
    parameter int SATURATE  = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load_en,
    input  logic [4*DIGITS-1:0] load_data,
    input  logic                up,
    input  logic                down,
    input  logic                cnt_en,
    output logic [4*DIGITS-1:0] out,
    output logic                carry_out,
    output logic                borrow_out,
    output logic                load_err
);

    localparam int          W         = 4 * DIGITS;
    localparam logic [63:0] MIN_FULL  = int_to_bcd(MIN_VAL, DIGITS);
    localparam logic [63:0] MAX_FULL  = int_to_bcd(MAX_VAL, DIGITS);
    localparam logic [63:0] RST_FULL  = int_to_bcd(RESET_VAL, DIGITS);
    localparam logic [W-1:0] MIN_BCD  = MIN_FULL[W-1:0];
    localparam logic [W-1:0] MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [W-1:0] RST_BCD  = RST_FULL[W-1:0];
    localparam bit           WRAP     = (SATURATE == 0);

    generate
        if (DIGITS < 1 || DIGITS > 9) begin : g_bad_digits
            $error("bcd_mod_counter: DIGITS must be 1..9");
        end else if (MIN_VAL < 0 || MIN_VAL > MAX_VAL || MAX_VAL > 10**DIGITS - 1) begin : g_bad_range
            $error("bcd_mod_counter: need 0 <= MIN_VAL <= MAX_VAL <= 10**DIGITS-1");
        end else if (RESET_VAL < 0 || RESET_VAL > 10**DIGITS - 1) begin : g_bad_reset
            $error("bcd_mod_counter: RESET_VAL must fit in DIGITS decimal digits");
        end else if (SATURATE != 0 && SATURATE != 1) begin : g_bad_sat
            $error("bcd_mod_counter: SATURATE must be 0 or 1");
        end
    endgenerate

    logic           up_req;
    logic           down_req;
    logic [DIGITS:0] chain;
    logic [W-1:0]   stepped;
    logic           step_over;

    assign up_req   = up & cnt_en;
    assign down_req = down & cnt_en;
    assign chain[0] = 1'b1;

    // The chain always steps; direction follows whichever request wins priority.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic c_o;
            logic b_o;
            bcd_digit_step u_step (
                .step_in   (chain[gi]),
                .down      (~up_req),
                .digit     (out[4*gi +: 4]),
                .next      (stepped[4*gi +: 4]),
                .carry_out (c_o),
                .borrow_out(b_o)
            );
            assign chain[gi+1] = c_o | b_o;
        end
    endgenerate

    // A ripple out of the top digit only happens from all-nines/all-zeros, i.e. a range end.
    assign step_over = chain[DIGITS];

    logic out_below;
    logic load_below;
    logic out_above;
    logic load_above;
    logic at_max;
    logic at_min;
    logic load_ok;

    generate
        if (MIN_VAL == 0) begin : g_min_zero
            assign out_below  = 1'b0;
            assign load_below = 1'b0;
        end else begin : g_min_nonzero
            assign out_below  = (out < MIN_BCD);
            assign load_below = (load_data < MIN_BCD);
        end
    endgenerate

    assign out_above  = (out > MAX_BCD);
    assign load_above = (load_data > MAX_BCD);
    assign at_max     = (out == MAX_BCD);
    assign at_min     = (out == MIN_BCD);
    assign load_ok    = is_valid_bcd(64'(load_data)) & ~load_below & ~load_above;

    logic [W-1:0] nxt;
    logic         nxt_carry;
    logic         nxt_borrow;
    logic         nxt_err;

    always_comb begin
        nxt        = out;
        nxt_carry  = 1'b0;
        nxt_borrow = 1'b0;
        nxt_err    = 1'b0;
        if (load_en) begin
            if (load_ok) begin
                nxt = load_data;
            end else begin
                nxt     = MIN_BCD;
                nxt_err = 1'b1;
            end
        end else if (up_req) begin
            if (out_below || out_above) begin
                nxt = MIN_BCD;
            end else if (at_max || step_over) begin
                if (WRAP) begin
                    nxt       = MIN_BCD;
                    nxt_carry = 1'b1;
                end
            end else begin
                nxt = stepped;
            end
        end else if (down_req) begin
            if (out_below || out_above) begin
                nxt = MAX_BCD;
            end else if (at_min || step_over) begin
                if (WRAP) begin
                    nxt        = MAX_BCD;
                    nxt_borrow = 1'b1;
                end
            end else begin
                nxt = stepped;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out        <= RST_BCD;
            carry_out  <= 1'b0;
            borrow_out <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            out        <= nxt;
            carry_out  <= nxt_carry;
            borrow_out <= nxt_borrow;
            load_err   <= nxt_err;
        end
    end

endmodule

// File: tb/tb_bcd_mod_counter.sv
// tb/tb_bcd_mod_counter.sv - three counter configurations driven in lockstep against a decimal model
module tb_bcd_mod_counter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       load_en = 1'b0;
    logic [7:0] load_data = 8'h00;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic       cnt_en = 1'b0;

    logic [7:0] dout [3];
    logic       dcar [3];
    logic       dbor [3];
    logic       derr [3];

    always #5 clk = ~clk;

    // 0: 1..12 wrap, reset 0; 1: 0..59 wrap, reset 75; 2: 1..12 saturate, reset 5
    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(0), .SATURATE(0)) u_a (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_data(load_data),
        .up(up), .down(down), .cnt_en(cnt_en),
        .out(dout[0]), .carry_out(dcar[0]), .borrow_out(dbor[0]), .load_err(derr[0]));
    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(0), .MAX_VAL(59), .RESET_VAL(75), .SATURATE(0)) u_b (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_data(load_data),
        .up(up), .down(down), .cnt_en(cnt_en),
        .out(dout[1]), .carry_out(dcar[1]), .borrow_out(dbor[1]), .load_err(derr[1]));
    bcd_mod_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12), .RESET_VAL(5), .SATURATE(1)) u_c (
        .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_data(load_data),
        .up(up), .down(down), .cnt_en(cnt_en),
        .out(dout[2]), .carry_out(dcar[2]), .borrow_out(dbor[2]), .load_err(derr[2]));

    int p_min [3] = '{1, 0, 1};
    int p_max [3] = '{12, 59, 12};
    int p_rst [3] = '{0, 75, 5};
    int p_sat [3] = '{0, 0, 1};

    int mv [3];
    bit mc [3];
    bit mb [3];
    bit me [3];

    int checks = 0;
    int failures = 0;

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mv[k] = p_rst[k];
            mc[k] = 0; mb[k] = 0; me[k] = 0;
        end
    endtask

    task automatic model_edge();
        int hi, lo;
        hi = int'(load_data[7:4]);
        lo = int'(load_data[3:0]);
        for (int k = 0; k < 3; k++) begin
            mc[k] = 0; mb[k] = 0; me[k] = 0;
            if (load_en) begin
                if (hi > 9 || lo > 9 || hi*10 + lo < p_min[k] || hi*10 + lo > p_max[k]) begin
                    mv[k] = p_min[k];
                    me[k] = 1;
                end else begin
                    mv[k] = hi*10 + lo;
                end
            end else if (up && cnt_en) begin
                if (mv[k] < p_min[k] || mv[k] > p_max[k]) mv[k] = p_min[k];
                else if (mv[k] == p_max[k]) begin
                    if (p_sat[k] == 0) begin mv[k] = p_min[k]; mc[k] = 1; end
                end else mv[k] = mv[k] + 1;
            end else if (down && cnt_en) begin
                if (mv[k] < p_min[k] || mv[k] > p_max[k]) mv[k] = p_max[k];
                else if (mv[k] == p_min[k]) begin
                    if (p_sat[k] == 0) begin mv[k] = p_max[k]; mb[k] = 1; end
                end else mv[k] = mv[k] - 1;
            end
        end
    endtask

    task automatic apply(input logic [11:0] s);
        {load_en, load_data, up, down, cnt_en} = s;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== bcd(mv[k])) begin
                failures++;
                $display("FAIL reset dut%0d out got=%h exp=%h", k, dout[k], bcd(mv[k]));
            end
            checks++;
            if ({dcar[k], dbor[k], derr[k]} !== 3'b000) begin
                failures++;
                $display("FAIL reset dut%0d pulses got=%b exp=000", k, {dcar[k], dbor[k], derr[k]});
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_out_of_range_up();
        logic [11:0] seq [3];
        seq = '{{1'b0, 8'h00, 3'b101}, {1'b0, 8'h00, 3'b000}, {1'b0, 8'h00, 3'b101}};
        for (int i = 0; i < 3; i++) begin
            apply(seq[i]);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL oor_up step%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    task automatic test_wrap();
        logic [11:0] seq [9];
        seq = '{{1'b1, 8'h11, 3'b001}, {1'b0, 8'h00, 3'b101}, {1'b0, 8'h00, 3'b101},
                {1'b0, 8'h00, 3'b000}, {1'b0, 8'h00, 3'b011}, {1'b0, 8'h00, 3'b000},
                {1'b1, 8'h01, 3'b001}, {1'b0, 8'h00, 3'b011}, {1'b0, 8'h00, 3'b011}};
        for (int i = 0; i < 9; i++) begin
            apply(seq[i]);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL wrap step%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    task automatic test_bcd_ripple();
        logic [11:0] seq [7];
        seq = '{{1'b1, 8'h09, 3'b001}, {1'b0, 8'h00, 3'b101}, {1'b1, 8'h50, 3'b001},
                {1'b0, 8'h00, 3'b011}, {1'b1, 8'h59, 3'b001}, {1'b0, 8'h00, 3'b101},
                {1'b0, 8'h00, 3'b000}};
        for (int i = 0; i < 7; i++) begin
            apply(seq[i]);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL ripple step%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    task automatic test_load_err();
        logic [11:0] seq [6];
        seq = '{{1'b1, 8'h1A, 3'b001}, {1'b0, 8'h00, 3'b000}, {1'b1, 8'h13, 3'b001},
                {1'b1, 8'h05, 3'b101}, {1'b1, 8'h07, 3'b100}, {1'b1, 8'hA0, 3'b011}};
        for (int i = 0; i < 6; i++) begin
            apply(seq[i]);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL load_err step%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    task automatic test_saturate_priority();
        logic [11:0] seq [7];
        seq = '{{1'b1, 8'h12, 3'b001}, {1'b0, 8'h00, 3'b111}, {1'b0, 8'h00, 3'b111},
                {1'b0, 8'h00, 3'b101}, {1'b0, 8'h00, 3'b100}, {1'b0, 8'h00, 3'b010},
                {1'b1, 8'h01, 3'b011}};
        for (int i = 0; i < 7; i++) begin
            apply(seq[i]);
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL sat_prio step%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    task automatic test_async_reset();
        apply({1'b1, 8'h12, 3'b001});
        step();
        apply({1'b0, 8'h00, 3'b101});
        step();
        checks++;
        if (dcar[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_pre carry got=%b exp=1", dcar[0]);
        end
        apply({1'b0, 8'h00, 3'b000});
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== 3'b000) begin
                failures++;
                $display("FAIL async_reset dut%0d got=%h/%b exp=%h/000", k, dout[k],
                         {dcar[k], dbor[k], derr[k]}, bcd(mv[k]));
            end
        end
        reset_n = 1'b1;
        apply({1'b0, 8'h00, 3'b011});
        step();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                failures++;
                $display("FAIL oor_down dut%0d got=%h/%b exp=%h/%b", k, dout[k],
                         {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 1) == 0) d = bcd(int'($urandom_range(0, 99)));
            else d = 8'($urandom);
            apply({($urandom_range(0, 7) == 0), d, 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 3) != 0)});
            step();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (dout[k] !== bcd(mv[k]) || {dcar[k], dbor[k], derr[k]} !== {mc[k], mb[k], me[k]}) begin
                    failures++;
                    $display("FAIL random cyc%0d dut%0d got=%h/%b exp=%h/%b", i, k, dout[k],
                             {dcar[k], dbor[k], derr[k]}, bcd(mv[k]), {mc[k], mb[k], me[k]});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_out_of_range_up();
        test_wrap();
        test_bcd_ripple();
        test_load_err();
        test_saturate_priority();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
